// File: rtl/recip_scale_divider.sv
// Reciprocal-scale engine: floor((QMAX(qmode) << FRAC_BITS) / max_abs) via an iterative restoring divider.
// Optional round-to-nearest on the final quotient when RECIP_SCALE_ROUND_EN is defined.
module recip_scale_divider #(
  parameter int DATA_W         = 32,
  parameter int FRAC_BITS      = 24,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] max_abs,
  input  logic [1:0]        qmode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] reciprocal_scale,
  output logic              div_by_zero
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               armed;
  logic [DATA_W-1:0]  divisor;
  logic [DATA_W-1:0]  quo;
  logic [DATA_W-1:0]  rem;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  step_rem;
  logic [DATA_W-1:0]  step_quo;
  logic [DATA_W-1:0]  final_q;
  logic               accept;
  logic               last_iter;

  function automatic logic [DATA_W-1:0] qmax(input logic [1:0] mode);
    case (mode)
      2'd1:    qmax = DATA_W'(7);
      2'd2:    qmax = DATA_W'(255);
      default: qmax = DATA_W'(127);
    endcase
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_iter = (state == CALC) && (cnt == LAST_CNT);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps this block from inferring a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (max_abs == '0) ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; armed holds in_ready low through reset and until the first clock after it.
  always_comb begin
    in_ready  = (state == IDLE) && armed;
    out_valid = (state == DONE);
  end

  // BITS_PER_CYCLE chained restoring steps; the shifted remainder is one bit wider than the divisor.
  always_comb begin
    logic [DATA_W:0] wide;
    wide     = '0;
    step_rem = rem;
    step_quo = quo;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      wide     = {step_rem, step_quo[DATA_W-1]};
      step_quo = {step_quo[DATA_W-2:0], 1'b0};
      if (wide >= {1'b0, divisor}) begin
        wide        = wide - {1'b0, divisor};
        step_quo[0] = 1'b1;
      end
      step_rem = wide[DATA_W-1:0];
    end
  end

`ifdef RECIP_SCALE_ROUND_EN
  // Round half up: 2*remainder >= divisor, saturating at all-ones.
  always_comb begin
    final_q = step_quo;
    if (({step_rem, 1'b0} >= {1'b0, divisor}) && (step_quo != '1))
      final_q = step_quo + DATA_W'(1);
  end
`else
  assign final_q = step_quo;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor          <= '0;
      quo              <= '0;
      rem              <= '0;
      cnt              <= '0;
      reciprocal_scale <= '0;
      div_by_zero      <= 1'b0;
    end else begin
      if (accept) begin
        if (max_abs == '0) begin
          reciprocal_scale <= '0;
          div_by_zero      <= 1'b1;
        end else begin
          divisor <= max_abs;
          quo     <= qmax(qmode) << FRAC_BITS;
          rem     <= '0;
          cnt     <= '0;
        end
      end else if (state == CALC) begin
        rem <= step_rem;
        quo <= step_quo;
        cnt <= cnt + CNT_W'(1);
        if (last_iter) begin
          reciprocal_scale <= final_q;
          div_by_zero      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_recip_scale_divider.sv
// Directed self-checking bench for recip_scale_divider with hand-computed quotients.
// Expectations for rounding cases follow RECIP_SCALE_ROUND_EN when it is defined for the build.
module tb_recip_scale_divider;

  localparam int DATA_W = 32;
  localparam int BPC    = 1;
  localparam int N      = DATA_W / BPC;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] max_abs;
  logic [1:0]        qmode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] reciprocal_scale;
  logic              div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  recip_scale_divider #(
    .DATA_W(DATA_W),
    .FRAC_BITS(24),
    .BITS_PER_CYCLE(BPC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .max_abs(max_abs),
    .qmode(qmode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .reciprocal_scale(reciprocal_scale),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one request for exactly one edge.
  task automatic accept_req(input string tag, input logic [DATA_W-1:0] m, input logic [1:0] q);
    int w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    check({tag, "_in_ready"}, DATA_W'(in_ready), DATA_W'(1));
    in_valid = 1'b1;
    max_abs  = m;
    qmode    = q;
    tick();
    in_valid = 1'b0;
    max_abs  = 32'hDEAD_BEEF;
    qmode    = 2'd1;
  endtask

  // Latency is counted in clock edges after the acceptance edge.
  task automatic wait_result(input string tag, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, DATA_W'(lat), DATA_W'(exp_lat));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, DATA_W'(out_valid), DATA_W'(0));
    check({tag, "_in_ready_after"}, DATA_W'(in_ready), DATA_W'(1));
  endtask

  task automatic run_req(input string tag, input logic [DATA_W-1:0] m, input logic [1:0] q,
                         input logic [DATA_W-1:0] exp_val, input logic exp_dbz, input int exp_lat);
    accept_req(tag, m, q);
    wait_result(tag, exp_lat);
    check({tag, "_value"}, reciprocal_scale, exp_val);
    check({tag, "_dbz"}, DATA_W'(div_by_zero), DATA_W'(exp_dbz));
    handshake(tag);
  endtask

  logic [DATA_W-1:0] exp_div6;
  logic [DATA_W-1:0] exp_big;
  logic [DATA_W-1:0] exp_div9;
  logic [DATA_W-1:0] held;

  initial begin
`ifdef RECIP_SCALE_ROUND_EN
    exp_div6 = 32'd355117739;
    exp_big  = 32'd1;
    exp_div9 = 32'd13048946;
`else
    exp_div6 = 32'd355117738;
    exp_big  = 32'd0;
    exp_div9 = 32'd13048945;
`endif
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    max_abs   = '0;
    qmode     = 2'd0;

    #13;
    check("rst_in_ready", DATA_W'(in_ready), DATA_W'(0));
    check("rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
    check("rst_value", reciprocal_scale, DATA_W'(0));
    check("rst_dbz", DATA_W'(div_by_zero), DATA_W'(0));
    #9 reset_n = 1'b1;
    #1 check("rel_in_ready_pre_clk", DATA_W'(in_ready), DATA_W'(0));
    tick();
    check("rel_in_ready", DATA_W'(in_ready), DATA_W'(1));

    run_req("int8_m1",   32'd1,   2'd0, 32'h7F00_0000, 1'b0, N);
    run_req("int8_m6",   32'd6,   2'd0, exp_div6,      1'b0, N);
    run_req("int8_m3",   32'd3,   2'd0, 32'd710235477, 1'b0, N);
    run_req("uint8_255", 32'd255, 2'd2, 32'd16777216,  1'b0, N);
    run_req("int4_m1",   32'd1,   2'd1, 32'd117440512, 1'b0, N);
    run_req("q3_m1",     32'd1,   2'd3, 32'h7F00_0000, 1'b0, N);
    run_req("uint8_m7",  32'd7,   2'd2, 32'd611170011, 1'b0, N);
    run_req("big_div",   32'hFFFF_FFFF, 2'd2, exp_big, 1'b0, N);
    run_req("zero",      32'd0,   2'd0, 32'd0,         1'b1, 0);

    // Backpressure: result held for 5 cycles while a stray in_valid pulse is ignored.
    accept_req("bp", 32'd9, 2'd1);
    wait_result("bp", N);
    check("bp_value", reciprocal_scale, exp_div9);
    held = reciprocal_scale;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        max_abs  = 32'd0;
      end
      tick();
      in_valid = 1'b0;
      check("bp_hold_value", reciprocal_scale, held);
      check("bp_hold_dbz", DATA_W'(div_by_zero), DATA_W'(0));
      check("bp_hold_valid", DATA_W'(out_valid), DATA_W'(1));
      check("bp_hold_in_ready", DATA_W'(in_ready), DATA_W'(0));
    end
    handshake("bp");
    tick();
    tick();
    check("bp_no_capture", DATA_W'(out_valid), DATA_W'(0));

    // Reset during CALC aborts the request.
    accept_req("mid_rst", 32'd1, 2'd0);
    for (int i = 0; i < 10; i++) tick();
    check("mid_rst_busy", DATA_W'(in_ready), DATA_W'(0));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", DATA_W'(in_ready), DATA_W'(0));
    check("mid_rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
    check("mid_rst_value", reciprocal_scale, DATA_W'(0));
    check("mid_rst_dbz", DATA_W'(div_by_zero), DATA_W'(0));
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    check("mid_rst_no_result", DATA_W'(out_valid), DATA_W'(0));
    run_req("post_rst_m2", 32'd2, 2'd0, 32'd1065353216, 1'b0, N);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/recip_scale_divider.md
Name: recip_scale_divider

Overview:
- Parametrised reciprocal-scale engine for the quantisation path.
- Computes reciprocal_scale = floor((QMAX(qmode) << FRAC_BITS) / max_abs) with an iterative restoring divider that retires BITS_PER_CYCLE quotient bits per clock.
- Uses valid/ready handshakes on input and output.
- Supports three target formats (int8, int4, uint8), explicit divide-by-zero signalling, and optional round-to-nearest.
- Sits between the max-abs reduction unit and the requantiser.

Parameters:
- DATA_W, 32, width of max_abs, dividend, divisor and quotient.
- FRAC_BITS, 24, fractional bits of the result; (255 << FRAC_BITS) must fit in DATA_W bits.
- BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; legal values 1, 2, 4; must divide DATA_W.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- max_abs  in  DATA_W  unsigned divisor, sampled on input handshake
- qmode  in  2  QMAX select, sampled on input handshake: 0 = 127 (int8), 1 = 7 (int4), 2 = 255 (uint8), 3 = 127
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- reciprocal_scale  out  DATA_W  quotient
- div_by_zero  out  1  set with a result whose max_abs was 0

Behaviour:
- Reset values: in_ready = 0 during reset and 1 from the first clock after deassertion; out_valid = 0; reciprocal_scale = 0; div_by_zero = 0; internal state = IDLE; iteration counter = 0.
- Reset asserted mid-operation aborts immediately; no result is produced for the aborted request.
- IDLE state:
  - in_ready = 1.
  - On (in_valid && in_ready), the request is accepted at that edge.
  - If max_abs == 0: go to DONE with reciprocal_scale = 0 and div_by_zero = 1. out_valid is high the cycle after acceptance.
  - Otherwise: latch divisor = max_abs, dividend = QMAX(qmode) << FRAC_BITS, remainder = 0, counter = 0; go to CALC.
- CALC state:
  - in_ready = 0.
  - Each cycle performs BITS_PER_CYCLE chained restoring steps. Each step: shift {remainder, quotient} left by 1; if remainder >= divisor, subtract divisor and set quotient LSB.
  - Remainder compare is DATA_W+1 bits wide so no overflow occurs for any divisor.
  - N = DATA_W / BITS_PER_CYCLE cycles.
  - The final iteration edge writes reciprocal_scale, sets div_by_zero = 0, and enters DONE. out_valid is therefore high exactly N cycles after the acceptance edge.
- DONE state:
  - out_valid = 1; reciprocal_scale and div_by_zero are held stable; in_ready = 0.
  - On (out_valid && out_ready): out_valid drops at that edge and the state returns to IDLE.
  - No request overlap: a new request is accepted no earlier than the cycle after the output handshake.
- in_valid while in_ready = 0 is ignored and the request is not captured.
- Inputs max_abs and qmode may change freely outside the handshake edge.
- Quotient never exceeds DATA_W bits because the dividend fits in DATA_W.

Optional Feature:
- Macro: RECIP_SCALE_ROUND_EN.
- Defined:
  - At the final CALC edge, if 2*remainder >= divisor (compared at DATA_W+1 bits), the quotient is incremented.
  - The increment saturates at all-ones.
  - Latency is unchanged.
- Undefined: result is the truncated quotient.
- Zero-divisor behaviour is identical in both builds.

Test Plan:
- Basic int8 (DATA_W=32, FRAC_BITS=24, BITS_PER_CYCLE=1), qmode=0, max_abs=1 -> reciprocal_scale = 2130706432 (0x7F000000), div_by_zero = 0, out_valid exactly 32 cycles after acceptance.
- Rounding, qmode=0, max_abs=6:
  - Without RECIP_SCALE_ROUND_EN -> 355117738.
  - With RECIP_SCALE_ROUND_EN -> 355117739 (remainder 4).
  - max_abs=3 gives 710235477 in both builds.
- Modes: qmode=2, max_abs=255 -> 16777216; qmode=1, max_abs=1 -> 117440512; qmode=3, max_abs=1 -> 2130706432.
- Zero and radix:
  - max_abs=0 -> reciprocal_scale = 0, div_by_zero = 1, out_valid one cycle after acceptance.
  - Rebuilt with BITS_PER_CYCLE=4, max_abs=1 -> 0x7F000000 after 8 cycles.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles -> result and div_by_zero stay stable, in_ready stays 0, and a pulsed in_valid is not captured.
  - After the handshake, in_ready = 1 the next cycle.
- Reset mid-CALC: assert reset_n = 0 at CALC cycle 10 -> all outputs at reset values at once. After release, a new request with max_abs=2 returns 1065353216.
